bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter with run/pause control. It is the decrementing counterpart of the team's decade up-counter chain.
- Digits are cascaded internally with a borrow chain. A free-running prescaler generates decrement ticks from clk.
- Used for display countdowns and timeouts. It raises a level flag and a one-cycle pulse when the count reaches zero.

Parameters:
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS.
- TICK_DIV, 10, clk cycles per decrement tick while running; legal range >=1; 1 means decrement every cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear: count to 0, state to IDLE.
- load  input  1  synchronous load of load_val, state to IDLE.
- load_val  input  4*DIGITS  BCD preset; digit [3:0] is least significant.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- count  output  4*DIGITS  current BCD value.
- running  output  1  high in RUN.
- paused  output  1  high in PAUSED.
- done  output  1  level, high in DONE.
- done_pulse  output  1  one-cycle pulse on the IDLE/RUN-to-DONE transition.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, prescaler=0, state=IDLE.
  - running=0, paused=0, done=0, done_pulse=0.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: count and prescaler frozen.
  - DONE: count==0, holding.
- Priority each cycle: clear > load > start > pause.
  - clear: count<=0, prescaler<=0, state<=IDLE, no done_pulse.
  - load: count<=load_val, prescaler<=0, state<=IDLE. Any load_val digit >9 is stored as 9 (per-digit saturation).
- Transitions:
  - IDLE + start: count!=0 -> RUN with prescaler<=0; count==0 -> DONE with done_pulse=1 next cycle.
  - RUN + pause (start low) -> PAUSED; prescaler value retained.
  - PAUSED + start -> RUN; prescaler resumes from its retained value, not reset.
  - DONE + start: no effect. Only load or clear leaves DONE.
  - start and pause together: start wins. RUN stays RUN; PAUSED resumes.
- Prescaler and tick:
  - Increments only in RUN.
  - tick=1 when prescaler==TICK_DIV-1, then the prescaler wraps to 0.
  - With TICK_DIV=1, tick=1 every RUN cycle.
- Decrement on tick:
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - The borrow ripples within the same cycle.
  - Result available on count the cycle after the tick edge; latency 1.
- Terminal condition: if the tick takes count from 1 (all upper digits 0, digit0==1) to 0:
  - state<=DONE; done=1 and done_pulse=1 in the same cycle that count shows 0.
  - No wrap to 99..9 is ever produced by the FSM.
- Outputs are registered or decoded directly from state registers. done_pulse is high for exactly one cycle per DONE entry.
- Mid-operation events:
  - rst_n asserted in any state aborts immediately to the reset values.
  - load during RUN aborts the count, with no done_pulse.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> count=0x0000, running=paused=done=done_pulse=0; start with count 0 -> next cycle done=1, done_pulse=1 for 1 cycle.
- Borrow ripple, TICK_DIV=1: load 0x1000, start -> after first tick count=0x0999; after 1000 RUN cycles count=0x0000 with done=1 and one done_pulse.
- Prescaler, TICK_DIV=10: load 0x0003, start -> count changes every 10 cycles (0002, 0001, 0000); done_pulse 30 cycles after RUN entry.
- Pause/resume: TICK_DIV=10, load 0x0050, start, pause after 14 cycles (count=0049, prescaler=4) -> 20 paused cycles with count unchanged; start -> next decrement after 6 RUN cycles to 0x0048.
- Priority and saturation:
  - clear+load+start together -> count=0, IDLE.
  - load 0x00FA -> count=0x0099.
  - start+pause in PAUSED -> RUN.
- Async reset mid-run: during RUN at count=0x0123, pulse rst_n low between clock edges -> outputs go to reset values without waiting for clk; no done_pulse.

Source files
------------

// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - control/status bundle for the BCD countdown timer
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 4
);
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  paused;
    logic                  done;
    logic                  done_pulse;

    modport master (
        output clear, load, load_val, start, pause,
        input  count, running, paused, done, done_pulse
    );

    modport slave (
        input  clear, load, load_val, start, pause,
        output count, running, paused, done, done_pulse
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD down-counter with prescaler and run/pause FSM
module bcd_countdown_timer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_countdown_timer_if.slave bus
);
    localparam int CW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_pre;
    logic          r_done_pulse;

    logic [CW-1:0] w_load_sat;
    logic [CW-1:0] w_count_dec;
    logic          w_tick;
    logic          w_count_zero;
    logic          w_count_one;

    assign w_tick       = (r_state == S_RUN) && (r_pre == PRE_LAST);
    assign w_count_zero = (r_count == '0);
    assign w_count_one  = (r_count == COUNT_ONE);

    // Clamp every preset digit into the legal BCD range 0..9
    always_comb begin
        w_load_sat = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.load_val[4*d +: 4] > 4'd9) begin
                w_load_sat[4*d +: 4] = 4'd9;
            end else begin
                w_load_sat[4*d +: 4] = bus.load_val[4*d +: 4];
            end
        end
    end

    // Subtract one, letting the borrow ripple through all digits in the same cycle
    always_comb begin
        logic w_borrow;
        w_borrow    = 1'b1;
        w_count_dec = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (!w_borrow) begin
                w_count_dec[4*d +: 4] = r_count[4*d +: 4];
            end else if (r_count[4*d +: 4] == 4'd0) begin
                w_count_dec[4*d +: 4] = 4'd9;
            end else begin
                w_count_dec[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                w_borrow              = 1'b0;
            end
        end
    end

    // Control FSM, prescaler and count register; clear > load > start > pause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_pre        <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (bus.clear) begin
                r_count <= '0;
                r_pre   <= '0;
                r_state <= S_IDLE;
            end else if (bus.load) begin
                r_count <= w_load_sat;
                r_pre   <= '0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_pre <= '0;
                            if (w_count_zero) begin
                                r_state      <= S_DONE;
                                r_done_pulse <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        // start beats pause, so only a bare pause suspends counting
                        if (bus.pause && !bus.start) begin
                            r_state <= S_PAUSED;
                        end else begin
                            r_pre <= w_tick ? '0 : r_pre + 1'b1;
                            if (w_tick) begin
                                r_count <= w_count_dec;
                                // Reaching zero stops the FSM so the count never wraps to all nines
                                if (w_count_one) begin
                                    r_state      <= S_DONE;
                                    r_done_pulse <= 1'b1;
                                end
                            end
                        end
                    end
                    S_PAUSED: begin
                        // Prescaler is left untouched so the partial tick period is honoured on resume
                        if (bus.start) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.count      = r_count;
    assign bus.running    = (r_state == S_RUN);
    assign bus.paused     = (r_state == S_PAUSED);
    assign bus.done       = (r_state == S_DONE);
    assign bus.done_pulse = r_done_pulse;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for the BCD countdown timer
module tb_bcd_countdown_timer;
    typedef struct {
        int          cyc;
        logic [19:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n1;
    logic rst_n10;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   test_done = 1'b0;
    exp_t q1[$];
    exp_t q10[$];
    logic [19:0] prev1 = '0;
    logic [19:0] prev10 = '0;

    bcd_countdown_timer_if #(.DIGITS(4)) bus1 ();
    bcd_countdown_timer_if #(.DIGITS(4)) bus10 ();

    bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1)
    );

    bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(10)) dut10 (
        .clk   (clk),
        .rst_n (rst_n10),
        .bus   (bus10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic push(input int id, input int t, input logic [15:0] cnt,
                        input bit r, input bit p, input bit d, input bit dp);
        exp_t e;
        e.cyc = t;
        e.v   = {cnt, r, p, d, dp};
        if (id == 1) q1.push_back(e);
        else         q10.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive(input int id, input int t, input bit clr, input bit ld,
                         input logic [15:0] val, input bit st, input bit ps);
        at_cyc(t);
        if (id == 1) begin
            bus1.clear = clr; bus1.load = ld; bus1.load_val = val; bus1.start = st; bus1.pause = ps;
        end else begin
            bus10.clear = clr; bus10.load = ld; bus10.load_val = val; bus10.start = st; bus10.pause = ps;
        end
        @(negedge clk);
        if (id == 1) begin
            bus1.clear = 0; bus1.load = 0; bus1.start = 0; bus1.pause = 0;
        end else begin
            bus10.clear = 0; bus10.load = 0; bus10.start = 0; bus10.pause = 0;
        end
    endtask

    task automatic check_dut(input int id, input logic [19:0] cur, input logic [19:0] prev);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (id == 1) begin
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
        end else begin
            if (q10.size() > 0 && q10[0].cyc <= cyc) begin e = q10.pop_front(); have = 1'b1; end
        end
        if (have) begin
            checks++;
            if (e.cyc != cyc || cur != e.v) begin
                errors++;
                $display("FAIL dut%0d_snapshot cyc %0d: got count=%h run/pause/done/pulse=%b, expected count=%h run/pause/done/pulse=%b at cyc %0d",
                         id, cyc, cur[19:4], cur[3:0], e.v[19:4], e.v[3:0], e.cyc);
            end
        end else if (cur != prev) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_change cyc %0d: got count=%h run/pause/done/pulse=%b, expected unchanged count=%h run/pause/done/pulse=%b",
                     id, cyc, cur[19:4], cur[3:0], prev[19:4], prev[3:0]);
        end
    endtask

    // Monitor: compares each DUT's outputs against the scoreboard every cycle
    always @(negedge clk) begin
        logic [19:0] cur1;
        logic [19:0] cur10;
        cur1  = {bus1.count, bus1.running, bus1.paused, bus1.done, bus1.done_pulse};
        cur10 = {bus10.count, bus10.running, bus10.paused, bus10.done, bus10.done_pulse};
        check_dut(1, cur1, prev1);
        check_dut(10, cur10, prev10);
        prev1  = cur1;
        prev10 = cur10;
        if (test_done) begin
            while (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                checks++; errors++;
                $display("FAIL dut1_missing_event: got nothing, expected count=%h at cyc %0d", e.v[19:4], e.cyc);
            end
            while (q10.size() > 0) begin
                exp_t e;
                e = q10.pop_front();
                checks++; errors++;
                $display("FAIL dut10_missing_event: got nothing, expected count=%h at cyc %0d", e.v[19:4], e.cyc);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete, expected completion within time limit");
        $fatal(1, "timeout");
    end

    // Stimulus: directed vectors with expected snapshots pushed ahead of time
    initial begin
        int c;
        rst_n1 = 1'b1;
        rst_n10 = 1'b1;
        bus1.clear = 0; bus1.load = 0; bus1.load_val = '0; bus1.start = 0; bus1.pause = 0;
        bus10.clear = 0; bus10.load = 0; bus10.load_val = '0; bus10.start = 0; bus10.pause = 0;
        #2;
        rst_n1 = 1'b0;
        rst_n10 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        c = cyc;
        push(1, c + 1, 16'h0000, 0, 0, 0, 0);
        push(10, c + 1, 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        rst_n1 = 1'b1;
        rst_n10 = 1'b1;
        push(1, c + 2, 16'h0000, 0, 0, 0, 0);
        push(10, c + 2, 16'h0000, 0, 0, 0, 0);
        @(negedge clk);

        // start with count zero goes straight to DONE; DONE ignores start; clear leaves it
        c = cyc;
        push(10, c + 1, 16'h0000, 0, 0, 1, 1);
        push(10, c + 2, 16'h0000, 0, 0, 1, 0);
        push(10, c + 4, 16'h0000, 0, 0, 0, 0);
        drive(10, c, 0, 0, 16'h0000, 1, 0);
        drive(10, c + 2, 0, 0, 16'h0000, 1, 0);
        drive(10, c + 3, 1, 0, 16'h0000, 0, 0);
        at_cyc(c + 5);

        // borrow ripple with a tick every cycle: 1000 down to 0
        c = cyc;
        push(1, c + 1, 16'h1000, 0, 0, 0, 0);
        push(1, c + 2, 16'h1000, 1, 0, 0, 0);
        for (int k = 1; k < 1000; k++) push(1, c + 2 + k, to_bcd(1000 - k), 1, 0, 0, 0);
        push(1, c + 1002, 16'h0000, 0, 0, 1, 1);
        push(1, c + 1003, 16'h0000, 0, 0, 1, 0);
        drive(1, c, 0, 1, 16'h1000, 0, 0);
        drive(1, c + 1, 0, 0, 16'h0000, 1, 0);
        at_cyc(c + 1005);

        // prescaler of 10: 3 -> 0, done_pulse 30 cycles after RUN entry
        c = cyc;
        push(10, c + 1, 16'h0003, 0, 0, 0, 0);
        push(10, c + 2, 16'h0003, 1, 0, 0, 0);
        push(10, c + 12, 16'h0002, 1, 0, 0, 0);
        push(10, c + 22, 16'h0001, 1, 0, 0, 0);
        push(10, c + 32, 16'h0000, 0, 0, 1, 1);
        push(10, c + 33, 16'h0000, 0, 0, 1, 0);
        drive(10, c, 0, 1, 16'h0003, 0, 0);
        drive(10, c + 1, 0, 0, 16'h0000, 1, 0);
        at_cyc(c + 35);

        // pause at prescaler 4, hold 20 cycles, resume with start+pause
        c = cyc;
        push(10, c + 1, 16'h0050, 0, 0, 0, 0);
        push(10, c + 2, 16'h0050, 1, 0, 0, 0);
        push(10, c + 12, 16'h0049, 1, 0, 0, 0);
        push(10, c + 17, 16'h0049, 0, 1, 0, 0);
        push(10, c + 38, 16'h0049, 1, 0, 0, 0);
        push(10, c + 44, 16'h0048, 1, 0, 0, 0);
        push(10, c + 46, 16'h0000, 0, 0, 0, 0);
        drive(10, c, 0, 1, 16'h0050, 0, 0);
        drive(10, c + 1, 0, 0, 16'h0000, 1, 0);
        drive(10, c + 16, 0, 0, 16'h0000, 0, 1);
        drive(10, c + 37, 0, 0, 16'h0000, 1, 1);
        drive(10, c + 45, 1, 0, 16'h0000, 0, 0);
        at_cyc(c + 48);

        // priority, saturation, load aborting RUN, start+pause in RUN, terminal from 1
        c = cyc;
        push(10, c + 1, 16'h0777, 0, 0, 0, 0);
        push(10, c + 2, 16'h0000, 0, 0, 0, 0);
        push(10, c + 3, 16'h0099, 0, 0, 0, 0);
        push(10, c + 4, 16'h9993, 0, 0, 0, 0);
        push(10, c + 5, 16'h9993, 1, 0, 0, 0);
        push(10, c + 7, 16'h0001, 0, 0, 0, 0);
        push(10, c + 8, 16'h0001, 1, 0, 0, 0);
        push(10, c + 18, 16'h0000, 0, 0, 1, 1);
        push(10, c + 19, 16'h0000, 0, 0, 1, 0);
        push(10, c + 21, 16'h0000, 0, 0, 0, 0);
        drive(10, c, 0, 1, 16'h0777, 0, 0);
        drive(10, c + 1, 1, 1, 16'h0555, 1, 0);
        drive(10, c + 2, 0, 1, 16'h00FA, 0, 0);
        drive(10, c + 3, 0, 1, 16'hF9A3, 0, 0);
        drive(10, c + 4, 0, 0, 16'h0000, 1, 0);
        drive(10, c + 6, 0, 1, 16'h0001, 0, 0);
        drive(10, c + 7, 0, 0, 16'h0000, 1, 0);
        drive(10, c + 9, 0, 0, 16'h0000, 1, 1);
        drive(10, c + 20, 1, 0, 16'h0000, 0, 0);
        at_cyc(c + 23);

        // asynchronous reset pulse between clock edges while running at 0123
        c = cyc;
        push(10, c + 1, 16'h0123, 0, 0, 0, 0);
        push(10, c + 2, 16'h0123, 1, 0, 0, 0);
        push(10, c + 4, 16'h0000, 0, 0, 0, 0);
        drive(10, c, 0, 1, 16'h0123, 0, 0);
        drive(10, c + 1, 0, 0, 16'h0000, 1, 0);
        at_cyc(c + 3);
        @(posedge clk);
        #2;
        rst_n10 = 1'b0;
        #2;
        rst_n10 = 1'b1;
        at_cyc(c + 10);

        test_done = 1'b1;
    end
endmodule
